// File: rtl/uart_hex_pkg.sv
// Shared constants and enums for the ASCII-hex word loader.
package uart_hex_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_US = 8'h5F;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    DIGIT,
    SEP,
    EOL,
    BAD
  } byte_class_t;

endpackage

// File: rtl/uart_hex_word_loader_if.sv
// UART byte stream plus word output port of the hex word loader.
// Handshake: word moves on a clock edge where word_valid & word_ready are both 1;
// word_data is held stable while word_valid is 1 and word_valid never drops without a transfer.
interface uart_hex_word_loader_if #(parameter int WORD_W = 32);
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic              tx_busy;
  logic [7:0]        tx_din;
  logic              tx_wr_en;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    input  rx_data, rx_rdy, tx_busy, word_ready,
    output rx_rdy_clr, tx_din, tx_wr_en, word_data, word_valid
  );

  modport slave (
    output rx_data, rx_rdy, tx_busy, word_ready,
    input  rx_rdy_clr, tx_din, tx_wr_en, word_data, word_valid
  );
endinterface

// File: rtl/hex_ascii_decode.sv
// Classifies one received byte and extracts its hex nibble value.
module hex_ascii_decode
  import uart_hex_pkg::*;
#(
  parameter bit LOWER_EN = 1'b1
) (
  input  logic [7:0]  data,
  output byte_class_t cls,
  output logic [3:0]  nib
);

  always_comb begin
    cls = BAD;
    nib = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      cls = DIGIT;
      nib = data[3:0];
    end else if (data >= 8'h41 && data <= 8'h46) begin
      cls = DIGIT;
      nib = data[3:0] + 4'd9;
    end else if (LOWER_EN && data >= 8'h61 && data <= 8'h66) begin
      cls = DIGIT;
      nib = data[3:0] + 4'd9;
    end else if (data == ASCII_SP || data == ASCII_US) begin
      cls = SEP;
    end else if (data == ASCII_CR || data == ASCII_LF) begin
      cls = EOL;
    end
  end

endmodule

// File: rtl/uart_hex_word_loader.sv
// Packs ASCII hex digits from the UART into words with backpressure, echo,
// separator/end-of-line handling, a sticky error flag and a delivered-word counter.
module uart_hex_word_loader
  import uart_hex_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter bit ECHO_EN  = 1'b1,
  parameter bit LOWER_EN = 1'b1,
  parameter int CNT_W    = 8,
  localparam int NIBBLES = WORD_W / 4,
  localparam int NC_W    = $clog2(NIBBLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_hex_word_loader_if.master bus,
  output logic [NC_W-1:0]       nib_cnt,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      word_count,
  output state_t                state_dbg
);

  localparam logic [NC_W-1:0] LAST_NIB = NC_W'(NIBBLES - 1);

  state_t            state_q, state_d;
  logic              active_q;
  logic [WORD_W-1:0] partial_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              err_q;
  logic [NC_W-1:0]   nib_q;
  logic [CNT_W-1:0]  cnt_q;

  byte_class_t cls;
  logic [3:0]  nib;
  logic        consume, stall, complete, xfer, err_set;

  hex_ascii_decode #(.LOWER_EN(LOWER_EN)) u_decode (
    .data (bus.rx_data),
    .cls  (cls),
    .nib  (nib)
  );

  // A completing digit must wait while the previous word is still undelivered.
  assign stall    = (cls == DIGIT) && (nib_q == LAST_NIB) && valid_q && !bus.word_ready;
  assign xfer     = valid_q && bus.word_ready;
  assign complete = consume && (cls == DIGIT) && (nib_q == LAST_NIB);
  assign err_set  = consume && ((cls == BAD) || (cls == EOL && nib_q != '0));

  always_comb begin
    state_d        = state_q;
    consume        = 1'b0;
    bus.rx_rdy_clr = 1'b0;
    bus.tx_wr_en   = 1'b0;
    bus.tx_din     = 8'h00;
    case (state_q)
      IDLE: begin
        if (active_q && bus.rx_rdy && (!ECHO_EN || !bus.tx_busy) && !stall) begin
          consume        = 1'b1;
          bus.rx_rdy_clr = 1'b1;
          bus.tx_wr_en   = ECHO_EN;
          bus.tx_din     = ECHO_EN ? bus.rx_data : 8'h00;
          state_d        = HOLD;
        end
      end
      // The UART drops rdy one cycle after rdy_clr, so this cycle must not re-consume.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      partial_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      nib_q     <= '0;
      cnt_q     <= '0;
    end else begin
      active_q <= 1'b1;
      state_q  <= state_d;
      if (complete) begin
        word_q    <= (partial_q << 4) | WORD_W'(nib);
        valid_q   <= 1'b1;
        partial_q <= '0;
        nib_q     <= '0;
      end else begin
        if (xfer) valid_q <= 1'b0;
        if (consume && cls == DIGIT) begin
          partial_q <= (partial_q << 4) | WORD_W'(nib);
          nib_q     <= nib_q + NC_W'(1);
        end else if (consume && cls == EOL) begin
          partial_q <= '0;
          nib_q     <= '0;
        end
      end
      if (xfer) cnt_q <= cnt_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign bus.word_data  = word_q;
  assign bus.word_valid = valid_q;
  assign nib_cnt        = nib_q;
  assign err            = err_q;
  assign word_count     = cnt_q;
  assign state_dbg      = state_q;

endmodule
